ble_rx_pkt_ctrl: RTL and testbench
==================================

BLE_RX_PKT_CTRL -- requirements
Module: ble_rx_pkt_ctrl

Interface
REQ-001 SHALL have parameter ACCESS_ADDR, default 32'h8E89BED6, the access address matched against the received bit stream.
REQ-002 SHALL have parameter MAX_LEN, default 37, the maximum legal PDU payload length in bytes.
REQ-003 SHALL have parameter TIMEOUT, default 1023, the maximum clk cycles allowed between bit strobes inside a packet.
REQ-004 SHALL have port clk, input, 1, the single system clock.
REQ-005 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-006 SHALL have port enable, input, 1, which arms the sequencer; deasserting it forces IDLE.
REQ-007 SHALL have port bit_valid, input, 1, the demodulator "update" strobe: one cycle per received bit.
REQ-008 SHALL have port bit_in, input, 1, the demodulated bit, sampled only when bit_valid=1.
REQ-009 SHALL have port byte_valid, output, 1, a one-cycle pulse that qualifies byte_data.
REQ-010 SHALL have port byte_data, output, 8, the assembled byte, LSB received first.
REQ-011 SHALL have port pkt_start, output, 1, a one-cycle pulse when the access address is matched.
REQ-012 SHALL have port pkt_done, output, 1, a one-cycle pulse at the end of the CRC field.
REQ-013 SHALL have port crc_ok, output, 1, the CRC result, valid from pkt_done until the next pkt_start.
REQ-014 SHALL have port pkt_abort, output, 1, a one-cycle pulse on timeout or an illegal length.
REQ-015 SHALL have port state, output, 3, the current FSM state for debug.

Function
REQ-016 SHALL implement the FSM states IDLE=0, SEARCH=1, HEADER=2, PAYLOAD=3, CRC=4.
REQ-017 SHALL move IDLE->SEARCH on enable=1, and any state->IDLE on enable=0, with all partial packet data discarded.
REQ-018 In SEARCH, SHALL shift bit_in into a 32-bit register LSB-first on each bit_valid, and move to HEADER with pkt_start in the cycle after the bit that makes the register equal ACCESS_ADDR.
REQ-019 In HEADER, SHALL collect 16 bits, emit 2 bytes on byte_valid, and latch byte 1 as len.
REQ-020 On header completion, SHALL go to PAYLOAD if 0<len<=MAX_LEN, go to CRC if len=0, and otherwise pulse pkt_abort and return to SEARCH.
REQ-021 In PAYLOAD, SHALL emit exactly len bytes, then go to CRC.
REQ-022 In CRC, SHALL collect 24 bits, then pulse pkt_done, set crc_ok, and return to SEARCH.
REQ-023 SHALL assert byte_valid exactly one cycle after the bit_valid of each byte's 8th bit; byte_valid SHALL never fire in IDLE or SEARCH.
REQ-024 SHALL compute CRC-24 (polynomial 0x00065B, init 0x555555, LSB-first) over the header and payload bits; crc_ok=1 iff the computed value equals the received 24 bits, with the field's first-received bit at CRC bit 23.
REQ-025 SHALL run a gap counter in HEADER, PAYLOAD and CRC that clears on bit_valid; on reaching TIMEOUT it SHALL pulse pkt_abort and return to SEARCH.
REQ-026 SHALL give enable=0 priority over timeout, and timeout priority over bit processing in the same cycle.
REQ-027 SHALL clear the access-address shift register on every entry to SEARCH.
REQ-028 SHALL allow back-to-back packets: bits after pkt_done SHALL be searched with no dead cycle.

Reset
REQ-029 While rst_n=0, SHALL hold state=IDLE and drive byte_valid, byte_data, pkt_start, pkt_done, crc_ok, pkt_abort, and all counters and shift registers to 0.
REQ-030 SHALL leave reset synchronously to clk, with the first transition possible on the first clk edge after rst_n rises.

Structure
REQ-031 SHALL place the state encoding, the CRC polynomial and init constants, and the field widths (AA=32, HDR=16, CRC=24) in shared package ble_rx_pkg.
REQ-032 SHALL implement the CRC as sub-module ble_crc24, with ports clk, rst_n, init, en and din, and a 24-bit crc output.

Verification
REQ-033 Bench SHALL send AA 0x8E89BED6, header 0x02,0x03, payload 0xAA,0xBB,0xCC and a correct CRC, and see pkt_start, 5 byte_valid pulses with bytes 02 03 AA BB CC, pkt_done, and crc_ok=1.
REQ-034 Bench SHALL repeat REQ-033 with one CRC bit flipped and see pkt_done with crc_ok=0.
REQ-035 Bench SHALL send a header with len=0x40 and see pkt_abort after the 2nd header byte, state=SEARCH, and no payload bytes.
REQ-036 Bench SHALL stop bit strobes after payload byte 1 and see pkt_abort exactly TIMEOUT cycles after the last bit_valid.
REQ-037 Bench SHALL drop enable during PAYLOAD and then re-assert it, and see state=IDLE the next cycle with no pkt_done, then a clean capture of the following packet.
REQ-038 Bench SHALL assert rst_n=0 mid-PAYLOAD and see all outputs 0 and state=0 immediately, before any clk edge.

Source files
------------

// File: rtl/ble_rx_pkg.sv
// Shared definitions for the BLE receive packet controller:
// FSM encoding, CRC-24 constants and on-air field widths.
package ble_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEARCH  = 3'd1,
        ST_HEADER  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CRC     = 3'd4
    } state_t;

    localparam logic [23:0] CRC_POLY = 24'h00065B;
    localparam logic [23:0] CRC_INIT = 24'h555555;

    localparam int AA_W  = 32;
    localparam int HDR_W = 16;
    localparam int CRC_W = 24;

endpackage

// File: rtl/ble_crc24.sv
// Serial BLE CRC-24 (LSB-first data, Galois form); crc[23] is the first bit sent on air.
module ble_crc24
    import ble_rx_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic             en,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    logic feedback;

    assign feedback = crc[CRC_W-1] ^ din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (init) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= {crc[CRC_W-2:0], 1'b0} ^ (feedback ? CRC_POLY : '0);
        end
    end

endmodule

// File: rtl/ble_rx_pkt_ctrl.sv
// BLE receive packet sequencer: access-address search, header/payload byte assembly,
// CRC-24 check, inter-bit timeout. bit_valid is a one-cycle strobe with no back-pressure.
module ble_rx_pkt_ctrl
    import ble_rx_pkg::*;
#(
    parameter logic [AA_W-1:0] ACCESS_ADDR = 32'h8E89BED6,
    parameter int              MAX_LEN     = 37,
    parameter int              TIMEOUT     = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       pkt_start,
    output logic       pkt_done,
    output logic       crc_ok,
    output logic       pkt_abort,
    output logic [2:0] state
);

    localparam int         GAP_W     = $clog2(TIMEOUT + 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [4:0] HDR_LAST  = 5'(HDR_W - 1);
    localparam logic [4:0] CRC_LAST  = 5'(CRC_W - 1);

    state_t           state_q, state_d;
    logic             start_d, done_d, abort_d, bv_d;
    // Shift registers hold all but the incoming bit; the incoming bit completes the word.
    logic [AA_W-2:0]  aa_sr;
    logic [AA_W-1:0]  aa_nxt;
    logic [6:0]       byte_sr;
    logic [7:0]       byte_nxt;
    logic [CRC_W-2:0] crc_rx;
    logic [CRC_W-1:0] crc_rx_nxt;
    logic [CRC_W-1:0] crc_calc;
    logic [4:0]       bit_cnt;
    logic [7:0]       len_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             in_pkt, timeout, take_bit, state_chg, hdr_last_bit, crc_en;

    assign in_pkt       = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD) || (state_q == ST_CRC);
    assign timeout      = in_pkt && (gap_cnt == GAP_W'(TIMEOUT - 1));
    assign take_bit     = bit_valid && enable && !timeout;
    assign aa_nxt       = {bit_in, aa_sr};
    assign byte_nxt     = {bit_in, byte_sr};
    assign crc_rx_nxt   = {crc_rx, bit_in};
    assign state_chg    = (state_d != state_q);
    assign hdr_last_bit = (state_q == ST_HEADER) && take_bit && (bit_cnt == HDR_LAST);
    assign crc_en       = take_bit && ((state_q == ST_HEADER) || (state_q == ST_PAYLOAD));
    assign state        = state_q;

    ble_crc24 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (start_d),
        .en    (crc_en),
        .din   (bit_in),
        .crc   (crc_calc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        abort_d = 1'b0;
        bv_d    = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_SEARCH;
            ST_SEARCH: begin
                if (take_bit && (aa_nxt == ACCESS_ADDR)) begin
                    state_d = ST_HEADER;
                    start_d = 1'b1;
                end
            end
            ST_HEADER: begin
                if (timeout) begin
                    abort_d = 1'b1;
                    state_d = ST_SEARCH;
                end else if (take_bit) begin
                    bv_d = (bit_cnt[2:0] == 3'd7);
                    if (bit_cnt == HDR_LAST) begin
                        if (byte_nxt == 8'd0) begin
                            state_d = ST_CRC;
                        end else if (byte_nxt <= MAX_LEN_B) begin
                            state_d = ST_PAYLOAD;
                        end else begin
                            abort_d = 1'b1;
                            state_d = ST_SEARCH;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (timeout) begin
                    abort_d = 1'b1;
                    state_d = ST_SEARCH;
                end else if (take_bit && (bit_cnt[2:0] == 3'd7)) begin
                    bv_d = 1'b1;
                    if (len_cnt == 8'd1) begin
                        state_d = ST_CRC;
                    end
                end
            end
            ST_CRC: begin
                if (timeout) begin
                    abort_d = 1'b1;
                    state_d = ST_SEARCH;
                end else if (take_bit && (bit_cnt == CRC_LAST)) begin
                    done_d  = 1'b1;
                    state_d = ST_SEARCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Dropping enable wins over everything, including a timeout in the same cycle.
        if (!enable) begin
            state_d = ST_IDLE;
            start_d = 1'b0;
            done_d  = 1'b0;
            abort_d = 1'b0;
            bv_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_valid <= 1'b0;
            byte_data  <= '0;
            pkt_start  <= 1'b0;
            pkt_done   <= 1'b0;
            pkt_abort  <= 1'b0;
            crc_ok     <= 1'b0;
            aa_sr      <= '0;
            byte_sr    <= '0;
            crc_rx     <= '0;
            bit_cnt    <= '0;
            len_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            byte_valid <= bv_d;
            pkt_start  <= start_d;
            pkt_done   <= done_d;
            pkt_abort  <= abort_d;
            if (bv_d) begin
                byte_data <= byte_nxt;
            end
            if (start_d) begin
                crc_ok <= 1'b0;
            end else if (done_d) begin
                crc_ok <= (crc_rx_nxt == crc_calc);
            end

            if (state_chg) begin
                bit_cnt <= '0;
                gap_cnt <= '0;
            end else begin
                if (take_bit && in_pkt) begin
                    bit_cnt <= (state_q == ST_PAYLOAD) ? {2'b00, bit_cnt[2:0] + 3'd1}
                                                       : bit_cnt + 5'd1;
                end
                gap_cnt <= (bit_valid || !in_pkt) ? '0 : gap_cnt + GAP_W'(1);
            end

            if ((state_d == ST_IDLE) || ((state_d == ST_SEARCH) && (state_q != ST_SEARCH))) begin
                aa_sr <= '0;
            end else if ((state_q == ST_SEARCH) && take_bit) begin
                aa_sr <= aa_nxt[AA_W-1:1];
            end

            if (state_d == ST_IDLE) begin
                byte_sr <= '0;
                crc_rx  <= '0;
                len_cnt <= '0;
            end else begin
                if (take_bit && in_pkt) begin
                    byte_sr <= byte_nxt[7:1];
                end
                // len_cnt latches the length byte, then counts remaining payload bytes.
                if (hdr_last_bit) begin
                    len_cnt <= byte_nxt;
                end else if ((state_q == ST_PAYLOAD) && bv_d) begin
                    len_cnt <= len_cnt - 8'd1;
                end
                if ((state_q == ST_CRC) && take_bit) begin
                    crc_rx <= crc_rx_nxt[CRC_W-2:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_ble_rx_pkt_ctrl.sv
// Directed bench for ble_rx_pkt_ctrl: packet vector table plus timeout, enable-drop,
// back-to-back and asynchronous-reset sequences.
module tb_ble_rx_pkt_ctrl;

    localparam logic [31:0] AA      = 32'h8E89BED6;
    localparam int          MAX_LEN = 37;
    localparam int          TIMEOUT = 100;

    logic       clk = 1'b0;
    logic       rst_n, enable, bit_valid, bit_in;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       pkt_start, pkt_done, crc_ok, pkt_abort;
    logic [2:0] state;

    ble_rx_pkt_ctrl #(
        .ACCESS_ADDR (AA),
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .pkt_start  (pkt_start),
        .pkt_done   (pkt_done),
        .crc_ok     (crc_ok),
        .pkt_abort  (pkt_abort),
        .state      (state)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] hdr0;
        logic [7:0] len;
        logic [7:0] base;
        logic       flip;
        logic       exp_abort;
        logic       exp_ok;
    } pkt_vec_t;

    pkt_vec_t    vecs [8];
    int          total = 0;
    int          bad = 0;
    int          start_cnt = 0;
    int          done_cnt = 0;
    int          abort_cnt = 0;
    int unsigned gap_max = 2;
    logic [7:0]  exp_q [$];
    logic [7:0]  mon_exp;
    logic [23:0] m_crc;
    logic [31:0] aa_v = AA;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: bytes and pulse counts sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (byte_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got %0h expected none", byte_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("byte", 32'(byte_data), 32'(mon_exp));
                end
            end
            if (pkt_start) start_cnt++;
            if (pkt_done)  done_cnt++;
            if (pkt_abort) abort_cnt++;
        end
    end

    // driver tasks; the CRC model uses the bit-reversed register form
    task automatic tx_bit(input logic b, input logic upd);
        logic fb;
        if (upd) begin
            fb    = m_crc[0] ^ b;
            m_crc = (m_crc >> 1) ^ (fb ? 24'hDA6000 : 24'h000000);
        end
        repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk);
            #1;
        end
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic tx_byte(input logic [7:0] v, input logic upd);
        for (int i = 0; i < 8; i++) tx_bit(v[i], upd);
    endtask

    task automatic tx_aa();
        for (int i = 0; i < 32; i++) tx_bit(aa_v[i], 1'b0);
    endtask

    task automatic tx_header(input logic [7:0] h0, input logic [7:0] len);
        m_crc = 24'hAAAAAA;
        exp_q.push_back(h0);
        exp_q.push_back(len);
        tx_byte(h0, 1'b1);
        tx_byte(len, 1'b1);
    endtask

    task automatic tx_payload(input int n, input logic [7:0] base);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = base + 8'(i * 17);
            exp_q.push_back(b);
            tx_byte(b, 1'b1);
        end
    endtask

    task automatic tx_crc(input logic flip);
        logic [23:0] w;
        w = m_crc;
        if (flip) w[5] = ~w[5];
        for (int i = 0; i < 24; i++) tx_bit(w[i], 1'b0);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_pkt(input pkt_vec_t v, input string tag);
        int s0 = start_cnt;
        int d0 = done_cnt;
        int a0 = abort_cnt;
        tx_aa();
        tx_header(v.hdr0, v.len);
        if (!v.exp_abort) begin
            tx_payload(int'(v.len), v.base);
            tx_crc(v.flip);
        end
        wait_cycles(3);
        check({tag, "_start"}, 32'(start_cnt - s0), 32'd1);
        check({tag, "_done"},  32'(done_cnt - d0),  32'(!v.exp_abort));
        check({tag, "_abort"}, 32'(abort_cnt - a0), 32'(v.exp_abort));
        if (!v.exp_abort) check({tag, "_crc_ok"}, 32'(crc_ok), 32'(v.exp_ok));
        check({tag, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_state"}, 32'(state), 32'd1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, d0, a0, k;
        logic seen;

        vecs[0] = '{hdr0: 8'h02, len: 8'h03, base: 8'hAA, flip: 1'b0, exp_abort: 1'b0, exp_ok: 1'b1};
        vecs[1] = '{hdr0: 8'h02, len: 8'h03, base: 8'hAA, flip: 1'b1, exp_abort: 1'b0, exp_ok: 1'b0};
        vecs[2] = '{hdr0: 8'h05, len: 8'h00, base: 8'h00, flip: 1'b0, exp_abort: 1'b0, exp_ok: 1'b1};
        vecs[3] = '{hdr0: 8'h02, len: 8'h40, base: 8'h00, flip: 1'b0, exp_abort: 1'b1, exp_ok: 1'b0};
        vecs[4] = '{hdr0: 8'h01, len: 8'h01, base: 8'h5A, flip: 1'b0, exp_abort: 1'b0, exp_ok: 1'b1};
        vecs[5] = '{hdr0: 8'h02, len: 8'h25, base: 8'h01, flip: 1'b0, exp_abort: 1'b0, exp_ok: 1'b1};
        vecs[6] = '{hdr0: 8'h02, len: 8'h26, base: 8'h00, flip: 1'b0, exp_abort: 1'b1, exp_ok: 1'b0};
        vecs[7] = '{hdr0: 8'h0E, len: 8'h04, base: 8'h11, flip: 1'b1, exp_abort: 1'b0, exp_ok: 1'b0};

        rst_n     = 1'b1;
        enable    = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_outputs",
              32'({state, byte_valid, byte_data, pkt_start, pkt_done, crc_ok, pkt_abort}), 32'd0);
        wait_cycles(3);
        rst_n  = 1'b1;
        enable = 1'b1;
        check("reset_release_state", 32'(state), 32'd0);
        wait_cycles(1);
        check("first_edge_search", 32'(state), 32'd1);

        for (int i = 0; i < 8; i++) run_pkt(vecs[i], $sformatf("vec%0d", i));

        // back-to-back packets, no idle cycle between CRC end and the next access address
        gap_max = 0;
        s0 = start_cnt;
        d0 = done_cnt;
        tx_aa();
        tx_header(8'h02, 8'h03);
        tx_payload(3, 8'hAA);
        tx_crc(1'b0);
        tx_aa();
        tx_header(8'h02, 8'h01);
        tx_payload(1, 8'h77);
        tx_crc(1'b0);
        gap_max = 2;
        wait_cycles(3);
        check("b2b_start", 32'(start_cnt - s0), 32'd2);
        check("b2b_done", 32'(done_cnt - d0), 32'd2);
        check("b2b_crc_ok", 32'(crc_ok), 32'd1);
        check("b2b_bytes_left", 32'(exp_q.size()), 32'd0);

        // bit strobes stop after the first payload byte
        a0 = abort_cnt;
        d0 = done_cnt;
        tx_aa();
        tx_header(8'h02, 8'h03);
        tx_payload(1, 8'h55);
        k    = 0;
        seen = 1'b0;
        while (!seen && k < TIMEOUT + 20) begin
            @(posedge clk);
            #1;
            k++;
            if (pkt_abort) seen = 1'b1;
        end
        check("timeout_cycles", 32'(k), 32'(TIMEOUT));
        check("timeout_state", 32'(state), 32'd1);
        wait_cycles(1);
        check("timeout_pulse_width", 32'(pkt_abort), 32'd0);
        check("timeout_abort_cnt", 32'(abort_cnt - a0), 32'd1);
        check("timeout_no_done", 32'(done_cnt - d0), 32'd0);
        check("timeout_bytes_left", 32'(exp_q.size()), 32'd0);

        // enable dropped mid-payload, then re-armed
        d0 = done_cnt;
        tx_aa();
        tx_header(8'h02, 8'h03);
        tx_payload(1, 8'hAA);
        enable = 1'b0;
        wait_cycles(1);
        check("en_drop_state", 32'(state), 32'd0);
        wait_cycles(4);
        check("en_drop_no_done", 32'(done_cnt - d0), 32'd0);
        check("en_drop_bytes_left", 32'(exp_q.size()), 32'd0);
        enable = 1'b1;
        wait_cycles(1);
        check("en_rearm_state", 32'(state), 32'd1);
        run_pkt(vecs[0], "rearm");

        // asynchronous reset mid-payload, checked before the next clock edge
        tx_aa();
        tx_header(8'h02, 8'h03);
        tx_payload(2, 8'h10);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              32'({state, byte_valid, byte_data, pkt_start, pkt_done, crc_ok, pkt_abort}), 32'd0);
        exp_q.delete();
        wait_cycles(2);
        rst_n = 1'b1;
        check("reset2_hold_idle", 32'(state), 32'd0);
        wait_cycles(1);
        check("reset2_search", 32'(state), 32'd1);
        run_pkt(vecs[0], "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
